// File: rtl/wb_port_arbiter_if.sv
// Bundle of pipeline writeback, mult/div offer and register-file write port signals
// shared between the writeback arbiter and its environment.
interface wb_port_arbiter_if;
    logic        i_reg_write;
    logic [1:0]  i_mem_to_reg;
    logic [4:0]  i_rd;
    logic [31:0] i_result;
    logic [31:0] i_mem_read_data;
    logic [31:0] i_pc_4;
    logic [31:0] i_imm_ext_out;
    logic        i_md_valid;
    logic [4:0]  i_md_rd;
    logic [31:0] i_md_data;
    logic        o_md_ready;
    logic        o_rf_we;
    logic [4:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;
    logic        o_stall_pipe;
    logic        o_md_pending;

    modport master (
        output i_reg_write, i_mem_to_reg, i_rd, i_result, i_mem_read_data,
               i_pc_4, i_imm_ext_out, i_md_valid, i_md_rd, i_md_data,
        input  o_md_ready, o_rf_we, o_rf_waddr, o_rf_wdata, o_stall_pipe, o_md_pending
    );

    modport slave (
        input  i_reg_write, i_mem_to_reg, i_rd, i_result, i_mem_read_data,
               i_pc_4, i_imm_ext_out, i_md_valid, i_md_rd, i_md_data,
        output o_md_ready, o_rf_we, o_rf_waddr, o_rf_wdata, o_stall_pipe, o_md_pending
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority, mult/div results
// queue in a FIFO and a starvation counter forces one-cycle stalls. Optional feature:
// WB_ARB_BYPASS_EN writes a mult/div result straight through when the port is idle.
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    wb_port_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PEND  = 2'b01,
        STALL = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [7:0]  wait_r;
    logic [7:0]  wait_nx_s;
    logic [7:0]  wait_upd_s;
    logic        stall_r;

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] count_s;
    logic [AW:0] count_nx_s;
    logic [4:0]  rd_mem_r   [DEPTH];
    logic [31:0] data_mem_r [DEPTH];

    logic        full_s;
    logic        empty_s;
    logic        pipe_wr_s;
    logic        grant_s;
    logic        accept_s;
    logic        bypass_s;
    logic        enq_s;

    logic        rf_we_s;
    logic [4:0]  rf_waddr_s;
    logic [31:0] rf_wdata_s;

    function automatic logic [31:0] wb_mux(
        input logic [1:0]  sel,
        input logic [31:0] result,
        input logic [31:0] mem_data,
        input logic [31:0] pc_4,
        input logic [31:0] imm
    );
        logic [31:0] val;
        case (sel)
            2'b00:   val = result;
            2'b01:   val = mem_data;
            2'b10:   val = pc_4;
            2'b11:   val = imm;
            default: val = 32'd0;
        endcase
        return val;
    endfunction

    // Extra pointer bit separates full from empty when the low bits match.
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign count_s = wr_ptr_r - rd_ptr_r;

    // While stalled the pipeline carries a bubble, so its inputs are disregarded.
    assign pipe_wr_s = reset && bus.i_reg_write && (bus.i_rd != 5'd0) && !stall_r;
    assign grant_s   = !empty_s && (!pipe_wr_s || stall_r);
    assign accept_s  = reset && bus.i_md_valid && !full_s;

`ifdef WB_ARB_BYPASS_EN
    assign bypass_s = empty_s && !pipe_wr_s && !stall_r && accept_s && (bus.i_md_rd != 5'd0);
`else
    assign bypass_s = 1'b0;
`endif

    // rd=0 results are accepted but never occupy a slot.
    assign enq_s      = accept_s && (bus.i_md_rd != 5'd0) && !bypass_s;
    assign count_nx_s = count_s + {{AW{1'b0}}, enq_s} - {{AW{1'b0}}, grant_s};

    // FIFO pointers; cleared asynchronously so a reset drops queued results at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (grant_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            rd_mem_r[wr_ptr_r[AW-1:0]]   <= bus.i_md_rd;
            data_mem_r[wr_ptr_r[AW-1:0]] <= bus.i_md_data;
        end
    end

    // Write port selection: queued mult/div head, then pipeline, then straight-through.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = 5'd0;
        rf_wdata_s = 32'd0;
        if (grant_s) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = rd_mem_r[rd_ptr_r[AW-1:0]];
            rf_wdata_s = data_mem_r[rd_ptr_r[AW-1:0]];
        end else if (pipe_wr_s) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = bus.i_rd;
            rf_wdata_s = wb_mux(bus.i_mem_to_reg, bus.i_result, bus.i_mem_read_data,
                                bus.i_pc_4, bus.i_imm_ext_out);
        end else if (bypass_s) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = bus.i_md_rd;
            rf_wdata_s = bus.i_md_data;
        end else begin
            rf_we_s    = 1'b0;
        end
    end

    // Next-state and starvation counter update.
    always_comb begin
        state_nx_s = state_r;
        wait_nx_s  = wait_r;
        wait_upd_s = grant_s ? 8'd0 : (wait_r + 8'd1);
        case (state_r)
            IDLE: begin
                wait_nx_s = 8'd0;
                if (enq_s) begin
                    state_nx_s = PEND;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            PEND: begin
                if (count_nx_s == {(AW+1){1'b0}}) begin
                    state_nx_s = IDLE;
                    wait_nx_s  = 8'd0;
                end else if (!grant_s && ((wait_upd_s == MAX_WAIT_C) || full_s)) begin
                    state_nx_s = STALL;
                    wait_nx_s  = 8'd0;
                end else begin
                    state_nx_s = PEND;
                    wait_nx_s  = wait_upd_s;
                end
            end
            STALL: begin
                wait_nx_s = 8'd0;
                if (count_nx_s == {(AW+1){1'b0}}) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = PEND;
                end
            end
            default: begin
                state_nx_s = IDLE;
                wait_nx_s  = 8'd0;
            end
        endcase
    end

    // State, counter and stall flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            wait_r  <= 8'd0;
            stall_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            wait_r  <= wait_nx_s;
            stall_r <= (state_nx_s == STALL);
        end
    end

    assign bus.o_md_ready   = !full_s;
    assign bus.o_md_pending = !empty_s;
    assign bus.o_stall_pipe = stall_r;
    assign bus.o_rf_we      = rf_we_s;
    assign bus.o_rf_waddr   = rf_waddr_s;
    assign bus.o_rf_wdata   = rf_wdata_s;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=4, MAX_WAIT=4).
module tb_wb_port_arbiter;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(4), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic pipe(input logic we, input logic [1:0] sel, input logic [4:0] rd);
        bus.i_reg_write  = we;
        bus.i_mem_to_reg = sel;
        bus.i_rd         = rd;
    endtask

    task automatic offer(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.i_md_valid = v;
        bus.i_md_rd    = rd;
        bus.i_md_data  = d;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        pipe(1'b0, 2'b00, 5'd0);
        offer(1'b0, 5'd0, 32'd0);
        bus.i_result        = 32'h1111_1111;
        bus.i_mem_read_data = 32'hDEAD_BEEF;
        bus.i_pc_4          = 32'h0000_0404;
        bus.i_imm_ext_out   = 32'hABCD_0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",   bus.o_md_ready,   32'd1);
        check("rst_pending", bus.o_md_pending, 32'd0);
        check("rst_we",      bus.o_rf_we,      32'd0);
        check("rst_stall",   bus.o_stall_pipe, 32'd0);
        check("rst_waddr",   bus.o_rf_waddr,   32'd0);
        check("rst_wdata",   bus.o_rf_wdata,   32'd0);
        reset = 1'b1;
        tick();

        // Pipeline source mux, same cycle
        pipe(1'b1, 2'b01, 5'd8);  settle();
        check("mux01_we",    bus.o_rf_we,    32'd1);
        check("mux01_waddr", bus.o_rf_waddr, 32'd8);
        check("mux01_wdata", bus.o_rf_wdata, 32'hDEAD_BEEF);
        tick();
        pipe(1'b1, 2'b00, 5'd31); settle();
        check("mux00_waddr", bus.o_rf_waddr, 32'd31);
        check("mux00_wdata", bus.o_rf_wdata, 32'h1111_1111);
        tick();
        pipe(1'b1, 2'b10, 5'd1);  settle();
        check("mux10_wdata", bus.o_rf_wdata, 32'h0000_0404);
        tick();
        pipe(1'b1, 2'b11, 5'd2);  settle();
        check("mux11_wdata", bus.o_rf_wdata, 32'hABCD_0000);
        tick();
        pipe(1'b1, 2'b01, 5'd0);  settle();
        check("rd0_we",    bus.o_rf_we,    32'd0);
        check("rd0_waddr", bus.o_rf_waddr, 32'd0);
        check("rd0_wdata", bus.o_rf_wdata, 32'd0);
        tick();

        // Mult/div result to r0 is discarded
        pipe(1'b0, 2'b00, 5'd0);
        offer(1'b1, 5'd0, 32'hFFFF_FFFF); settle();
        check("md_rd0_we", bus.o_rf_we, 32'd0);
        tick();
        offer(1'b0, 5'd0, 32'd0); settle();
        check("md_rd0_pending", bus.o_md_pending, 32'd0);
        check("md_rd0_we2",     bus.o_rf_we,      32'd0);
        tick();

        // Idle-slot drain
        offer(1'b1, 5'd5, 32'h0000_1234); settle();
`ifdef WB_ARB_BYPASS_EN
        check("drain_byp_we",    bus.o_rf_we,    32'd1);
        check("drain_byp_waddr", bus.o_rf_waddr, 32'd5);
        check("drain_byp_wdata", bus.o_rf_wdata, 32'h0000_1234);
`else
        check("drain_offer_we", bus.o_rf_we, 32'd0);
`endif
        tick();
        offer(1'b0, 5'd0, 32'd0); settle();
`ifdef WB_ARB_BYPASS_EN
        check("drain_byp_pending", bus.o_md_pending, 32'd0);
        check("drain_byp_we2",     bus.o_rf_we,      32'd0);
`else
        check("drain_pending", bus.o_md_pending, 32'd1);
        check("drain_we",      bus.o_rf_we,      32'd1);
        check("drain_waddr",   bus.o_rf_waddr,   32'd5);
        check("drain_wdata",   bus.o_rf_wdata,   32'h0000_1234);
`endif
        tick();
        settle();
        check("drain_done_pending", bus.o_md_pending, 32'd0);
        check("drain_done_we",      bus.o_rf_we,      32'd0);
        tick();

        // Starvation: continuous pipeline writes to r7
        pipe(1'b1, 2'b00, 5'd7);
        bus.i_result = 32'h0000_0077;
        offer(1'b1, 5'd9, 32'h0000_0099); settle();
        check("starve_enq_waddr", bus.o_rf_waddr, 32'd7);
        tick();
        offer(1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            settle();
            check($sformatf("starve_deny%0d_stall", i), bus.o_stall_pipe, 32'd0);
            check($sformatf("starve_deny%0d_waddr", i), bus.o_rf_waddr,   32'd7);
            tick();
        end
        settle();
        check("starve_stall", bus.o_stall_pipe, 32'd1);
        check("starve_waddr", bus.o_rf_waddr,   32'd9);
        check("starve_wdata", bus.o_rf_wdata,   32'h0000_0099);
        tick();
        settle();
        check("starve_after_stall",   bus.o_stall_pipe, 32'd0);
        check("starve_after_pending", bus.o_md_pending, 32'd0);
        check("starve_after_waddr",   bus.o_rf_waddr,   32'd7);
        tick();

        // Fill the FIFO under continuous pipeline writes
        for (int k = 1; k <= 4; k++) begin
            offer(1'b1, 5'(k), 32'h100 + 32'(k)); settle();
            check($sformatf("full_ready%0d", k), bus.o_md_ready, 32'd1);
            tick();
        end
        offer(1'b1, 5'd5, 32'h0000_0105); settle();
        check("full_ready_held", bus.o_md_ready,   32'd0);
        check("full_pre_stall",  bus.o_stall_pipe, 32'd0);
        check("full_pre_waddr",  bus.o_rf_waddr,   32'd7);
        tick();
        settle();
        check("full_ready_held2", bus.o_md_ready,   32'd0);
        check("full_stall1",      bus.o_stall_pipe, 32'd1);
        check("full_waddr1",      bus.o_rf_waddr,   32'd1);
        check("full_wdata1",      bus.o_rf_wdata,   32'h0000_0101);
        tick();
        offer(1'b0, 5'd0, 32'd0);
        for (int k = 2; k <= 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                settle();
                check($sformatf("full_deny_k%0d_stall", k), bus.o_stall_pipe, 32'd0);
                check($sformatf("full_deny_k%0d_waddr", k), bus.o_rf_waddr,   32'd7);
                tick();
            end
            settle();
            check($sformatf("full_stall_k%0d", k), bus.o_stall_pipe, 32'd1);
            check($sformatf("full_waddr_k%0d", k), bus.o_rf_waddr,   32'(k));
            check($sformatf("full_wdata_k%0d", k), bus.o_rf_wdata,   32'h100 + 32'(k));
            tick();
        end
        settle();
        check("full_done_pending", bus.o_md_pending, 32'd0);
        check("full_done_stall",   bus.o_stall_pipe, 32'd0);
        tick();

        // Simultaneous enqueue and grant keeps order
        offer(1'b1, 5'd10, 32'h0000_00AA);
        tick();
        offer(1'b1, 5'd11, 32'h0000_00BB);
        tick();
        pipe(1'b0, 2'b00, 5'd0);
        offer(1'b1, 5'd12, 32'h0000_00CC); settle();
        check("simul_ready", bus.o_md_ready, 32'd1);
        check("simul_waddr", bus.o_rf_waddr, 32'd10);
        check("simul_wdata", bus.o_rf_wdata, 32'h0000_00AA);
        tick();
        offer(1'b0, 5'd0, 32'd0); settle();
        check("simul_b_waddr",   bus.o_rf_waddr,   32'd11);
        check("simul_b_wdata",   bus.o_rf_wdata,   32'h0000_00BB);
        check("simul_b_pending", bus.o_md_pending, 32'd1);
        tick();
        settle();
        check("simul_c_waddr",   bus.o_rf_waddr,   32'd12);
        check("simul_c_wdata",   bus.o_rf_wdata,   32'h0000_00CC);
        check("simul_c_pending", bus.o_md_pending, 32'd1);
        tick();
        settle();
        check("simul_done_pending", bus.o_md_pending, 32'd0);
        check("simul_done_we",      bus.o_rf_we,      32'd0);
        tick();

        // Mid-run asynchronous reset with three entries queued
        pipe(1'b1, 2'b00, 5'd7);
        for (int k = 0; k < 3; k++) begin
            offer(1'b1, 5'(20 + k), 32'h200 + 32'(k));
            tick();
        end
        pipe(1'b0, 2'b00, 5'd0);
        offer(1'b0, 5'd0, 32'd0); settle();
        check("prerst_pending", bus.o_md_pending, 32'd1);
        check("prerst_waddr",   bus.o_rf_waddr,   32'd20);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_pending", bus.o_md_pending, 32'd0);
        check("midrst_we",      bus.o_rf_we,      32'd0);
        check("midrst_stall",   bus.o_stall_pipe, 32'd0);
        tick();
        reset = 1'b1;
        settle();
        check("postrst_ready",   bus.o_md_ready,   32'd1);
        check("postrst_pending", bus.o_md_pending, 32'd0);
        check("postrst_we",      bus.o_rf_we,      32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port behind the MEM/WB pipeline register.
- Shares that port between the in-order writeback stream and a long-latency mult/div unit. The mult/div unit returns results out of band through a small FIFO.
- Pipeline writes have priority. A starvation counter forces a one-cycle pipeline stall so queued mult/div results drain.

Parameters:
- DEPTH, 4, mult/div result FIFO entries (power of two, ≥2)
- MAX_WAIT, 4, consecutive denied cycles before a stall is forced (1..255)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- i_reg_write  in  1  MEM/WB write enable
- i_mem_to_reg  in  2  source select: 00 result, 01 mem_read_data, 10 pc_4, 11 imm_ext_out
- i_rd  in  5  MEM/WB destination register
- i_result  in  32  ALU result
- i_mem_read_data  in  32  load data
- i_pc_4  in  32  link address
- i_imm_ext_out  in  32  extended immediate (lui path)
- i_md_valid  in  1  mult/div result offered
- i_md_rd  in  5  mult/div destination
- i_md_data  in  32  mult/div result
- o_md_ready  out  1  FIFO can accept (= !full)
- o_rf_we  out  1  register-file write enable
- o_rf_waddr  out  5  write address
- o_rf_wdata  out  32  write data
- o_stall_pipe  out  1  registered; freeze IF..EX/MEM, bubble into MEM/WB
- o_md_pending  out  1  FIFO non-empty

Behaviour:
- Reset: FIFO empty, wait_cnt=0, state IDLE, o_stall_pipe=0, o_md_ready=1, o_md_pending=0, o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0.
- pipe_wr = i_reg_write && i_rd!=0. An rd=0 write is never issued.
- Enqueue when i_md_valid && o_md_ready. Entries with i_md_rd=0 are accepted and discarded (no FIFO slot used).
- o_md_ready = !full, combinational from state only. No enqueue is allowed while full, even with a same-cycle dequeue.
- grant_md = !empty && (!pipe_wr || o_stall_pipe).
- While o_stall_pipe=1, pipeline inputs are ignored. Upstream guarantees a bubble in that cycle.
- Write port, combinational, same cycle:
  - if grant_md: we=1, waddr/wdata = FIFO head; pop at the clock edge.
  - else if pipe_wr: we=1, waddr=i_rd, wdata = mux by i_mem_to_reg.
  - else: we=0, waddr=0, wdata=0.
- FSM, one transition per clock edge:
  - IDLE (empty): goes to PEND on an enqueue.
  - PEND (non-empty, no stall): on a deny, wait_cnt++. On a grant, wait_cnt=0.
    - If after the update wait_cnt==MAX_WAIT, go to STALL and set o_stall_pipe=1 from the next cycle.
    - If the FIFO becomes empty, go to IDLE with wait_cnt=0.
  - STALL: o_stall_pipe=1 for exactly one cycle; the head is guaranteed to be granted. Next state is PEND if entries remain (wait_cnt=0), else IDLE.
- Arrival at full: FIFO full and a deny also forces the transition to STALL, regardless of wait_cnt.
- Order: the FIFO is strictly FIFO. Pointers wrap modulo DEPTH, with an extra bit distinguishing full from empty.
- A simultaneous enqueue and grant when not full updates count by 0.
- Reset asserted mid-operation discards FIFO contents immediately, without waiting for a clock edge.

Optional Feature:
- Macro WB_ARB_BYPASS_EN.
- Defined: when the FIFO is empty, !pipe_wr, o_stall_pipe=0 and the offer is accepted (i_md_valid && i_md_rd!=0), the mult/div result is written straight through in the same cycle (o_rf_we=1, waddr=i_md_rd, wdata=i_md_data) and is not enqueued. wait_cnt is unaffected.
- Not defined: the result is always enqueued and written at the earliest the cycle after.

Test Plan:
- Reset check: drive reset=0 mid-run with 3 entries queued -> o_md_pending=0, o_rf_we=0 and o_stall_pipe=0 immediately; after release o_md_ready=1.
- Pipeline mux: i_reg_write=1, i_rd=8, i_mem_to_reg=01, i_mem_read_data=0xDEADBEEF -> same cycle o_rf_we=1, o_rf_waddr=8, o_rf_wdata=0xDEADBEEF. Repeat with i_rd=0 -> o_rf_we=0.
- Idle-slot drain: enqueue (rd=5, 0x1234) then pipeline bubble -> next cycle o_rf_waddr=5, o_rf_wdata=0x1234; o_md_pending falls after that edge. With WB_ARB_BYPASS_EN the write happens in the offer cycle.
- Starvation: 1 entry queued, pipe_wr=1 every cycle, MAX_WAIT=4 -> o_stall_pipe=1 in the cycle after the 4th deny, for exactly 1 cycle, with the entry written in that cycle.
- Full: 4 offers with pipe_wr=1 continuous -> o_md_ready=0 after the 4th accept; a 5th offer is held; stall forced; entries written in order rd 1,2,3,4 across stalls.
- Simultaneous: 2 queued, enqueue and grant in the same cycle -> count stays 2, and the order is preserved on the following drains.
